// File: rtl/incdec_seq.sv
// Sequenced pointer increment/decrement unit: NREG address registers updated by
// LOAD or repeated +/-1 / +/-2 steps, one command at a time, with done/wrap status.
module incdec_seq #(
  parameter int DATASIZE = 16,
  parameter int NREG     = 2,
  parameter int SELW     = 1,
  parameter int CNTW     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [SELW-1:0]     cmd_sel,
  input  logic [1:0]          cmd_op,
  input  logic                cmd_step2,
  input  logic [CNTW-1:0]     cmd_count,
  input  logic [DATASIZE-1:0] cmd_data,
  input  logic [SELW-1:0]     rd_sel,
  output logic [DATASIZE-1:0] rd_data,
  output logic                done,
  output logic                wrap
);

  // state  | meaning
  // S_IDLE | ready; LOAD/NOP complete here, INC/DEC launch into S_RUN
  // S_RUN  | applying one step per clock until rem_q runs out
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  state_t              state_q, state_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic                dec_q, dec_d;
  logic                step2_q, step2_d;
  logic [CNTW-1:0]     rem_q, rem_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic [DATASIZE-1:0] regs_q [NREG];
  logic [DATASIZE-1:0] regs_d [NREG];

  logic [DATASIZE-1:0] cur_val;
  logic                sel_hit;
  logic [DATASIZE-1:0] step_val;
  logic [DATASIZE:0]   step_res;
  logic                accept;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign done      = done_q;
  assign wrap      = wrap_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_sel == SELW'(i)) rd_data = regs_q[i];
    end
  end

  // Out-of-range selects never match, so they step without touching any register.
  always_comb begin
    cur_val = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (sel_q == SELW'(i)) begin
        cur_val = regs_q[i];
        sel_hit = 1'b1;
      end
    end
  end

  // The extra MSB of step_res is the carry (INC) or borrow (DEC).
  assign step_val = step2_q ? DATASIZE'(2) : DATASIZE'(1);
  assign step_res = dec_q ? ({1'b0, cur_val} - {1'b0, step_val})
                          : ({1'b0, cur_val} + {1'b0, step_val});

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dec_d   = dec_q;
    step2_d = step2_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wrap_d  = 1'b0;
          sel_d   = cmd_sel;
          dec_d   = (cmd_op == OP_DEC);
          step2_d = cmd_step2;
          case (cmd_op)
            OP_LOAD: begin
              for (int i = 0; i < NREG; i++) begin
                if (cmd_sel == SELW'(i)) regs_d[i] = cmd_data;
              end
              done_d = 1'b1;
            end
            OP_INC, OP_DEC: begin
              state_d = S_RUN;
              rem_d   = (cmd_count == '0) ? CNTW'(1) : cmd_count;
            end
            OP_NOP:  done_d = 1'b1;
            default: done_d = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        rem_d = rem_q - CNTW'(1);
        if (sel_hit) begin
          for (int i = 0; i < NREG; i++) begin
            if (sel_q == SELW'(i)) regs_d[i] = step_res[DATASIZE-1:0];
          end
          if (step_res[DATASIZE]) wrap_d = 1'b1;
        end
        if (rem_q <= CNTW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      dec_q   <= 1'b0;
      step2_q <= 1'b0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dec_q   <= dec_d;
      step2_q <= step2_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_incdec_seq.sv
// Bench for incdec_seq: table of commands with scoreboarded completion checks,
// followed by hand-written multi-cycle sequences (stepping trace, wrap, busy, reset).
module tb_incdec_seq;
  localparam int DW = 16;
  localparam int NR = 2;
  localparam int SW = 2;
  localparam int CW = 4;
  localparam logic [1:0] LD = 2'b00, INC = 2'b01, DEC = 2'b10, NOP = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_step2, done, wrap;
  logic [SW-1:0] cmd_sel, rd_sel;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [DW-1:0] cmd_data, rd_data;

  always #5 clk = ~clk;

  incdec_seq #(.DATASIZE(DW), .NREG(NR), .SELW(SW), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_op(cmd_op), .cmd_step2(cmd_step2), .cmd_count(cmd_count),
    .cmd_data(cmd_data), .rd_sel(rd_sel), .rd_data(rd_data), .done(done), .wrap(wrap)
  );

  typedef struct {
    logic [SW-1:0] sel; logic [1:0] op; logic step2; logic [CW-1:0] cnt; logic [DW-1:0] data;
    logic [DW-1:0] r0; logic [DW-1:0] r1; logic wr;
  } vec_t;
  typedef struct { logic [DW-1:0] r0; logic [DW-1:0] r1; logic wr; int lat; int nlow; } exp_t;

  vec_t vecs [16];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic read_reg(input logic [SW-1:0] s, output logic [DW-1:0] v);
    rd_sel = s;
    #1;
    v = rd_data;
  endtask

  task automatic drive(input logic [SW-1:0] s, input logic [1:0] op, input logic st2,
                       input logic [CW-1:0] cnt, input logic [DW-1:0] d);
    @(negedge clk);
    cmd_sel = s; cmd_op = op; cmd_step2 = st2; cmd_count = cnt; cmd_data = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_sel = SW'($urandom); cmd_op = 2'($urandom); cmd_step2 = 1'($urandom);
    cmd_count = CW'($urandom); cmd_data = DW'($urandom);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e, x;
    int n, cyc, nlow;
    bit got;
    logic [DW-1:0] rv;
    n = (v.cnt == '0) ? 1 : int'(v.cnt);
    e.r0 = v.r0; e.r1 = v.r1; e.wr = v.wr;
    e.lat  = (v.op == INC || v.op == DEC) ? n + 1 : 1;
    e.nlow = (v.op == INC || v.op == DEC) ? n : 0;
    sb.push_back(e);
    drive(v.sel, v.op, v.step2, v.cnt, v.data);
    cyc = 0; nlow = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!cmd_ready) nlow++;
      if (done) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL v%0d_timeout: no done within %0d cycles", idx, cyc);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    x = sb.pop_front();
    chk($sformatf("v%0d_latency", idx), cyc, x.lat);
    chk($sformatf("v%0d_ready_low", idx), nlow, x.nlow);
    chk($sformatf("v%0d_wrap", idx), {31'b0, wrap}, {31'b0, x.wr});
    read_reg(0, rv); chk($sformatf("v%0d_r0", idx), rv, x.r0);
    read_reg(1, rv); chk($sformatf("v%0d_r1", idx), rv, x.r1);
    read_reg(3, rv); chk($sformatf("v%0d_r3", idx), rv, 0);
    @(negedge clk);
    chk($sformatf("v%0d_done_single", idx), {31'b0, done}, 0);
  endtask

  initial begin
    logic [DW-1:0] rv;
    bit saw_done;
    vecs[0]  = '{0, LD,  0, 0,  16'h1234, 16'h1234, 16'h0000, 0};
    vecs[1]  = '{1, LD,  0, 0,  16'h0010, 16'h1234, 16'h0010, 0};
    vecs[2]  = '{1, INC, 1, 3,  16'h0000, 16'h1234, 16'h0016, 0};
    vecs[3]  = '{0, LD,  0, 0,  16'h0001, 16'h0001, 16'h0016, 0};
    vecs[4]  = '{0, DEC, 1, 1,  16'h0000, 16'hFFFF, 16'h0016, 1};
    vecs[5]  = '{0, INC, 0, 1,  16'h0000, 16'h0000, 16'h0016, 1};
    vecs[6]  = '{0, LD,  0, 0,  16'h00FF, 16'h00FF, 16'h0016, 0};
    vecs[7]  = '{0, INC, 0, 0,  16'h0000, 16'h0100, 16'h0016, 0};
    vecs[8]  = '{3, INC, 1, 5,  16'h0000, 16'h0100, 16'h0016, 0};
    vecs[9]  = '{2, LD,  0, 0,  16'hAAAA, 16'h0100, 16'h0016, 0};
    vecs[10] = '{0, NOP, 0, 0,  16'h5555, 16'h0100, 16'h0016, 0};
    vecs[11] = '{1, LD,  0, 0,  16'hFFFE, 16'h0100, 16'hFFFE, 0};
    vecs[12] = '{1, INC, 1, 2,  16'h0000, 16'h0100, 16'h0002, 1};
    vecs[13] = '{1, DEC, 0, 3,  16'h0000, 16'h0100, 16'hFFFF, 1};
    vecs[14] = '{1, INC, 1, 15, 16'h0000, 16'h0100, 16'h001D, 1};
    vecs[15] = '{0, DEC, 1, 4,  16'h0000, 16'h00F8, 16'h001D, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_op = '0; cmd_step2 = 1'b0;
    cmd_count = '0; cmd_data = '0; rd_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 1);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_wrap", {31'b0, wrap}, 0);
    read_reg(0, rv); chk("rst_r0", rv, 0);
    read_reg(1, rv); chk("rst_r1", rv, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Stepping trace: r1 visible after every edge of a running INC
    drive(1, LD, 0, 0, 16'h0010);
    @(negedge clk);
    chk("trace_load_done", {31'b0, done}, 1);
    drive(1, INC, 1, 3, 16'h0000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      read_reg(1, rv);
      chk($sformatf("trace_r1_c%0d", c), rv, 16'h0010 + 16'(2 * (c - 1)));
      chk($sformatf("trace_done_c%0d", c), {31'b0, done}, (c == 4) ? 1 : 0);
      chk($sformatf("trace_ready_c%0d", c), {31'b0, cmd_ready}, (c == 4) ? 1 : 0);
    end
    @(negedge clk);
    chk("trace_done_after", {31'b0, done}, 0);

    // Wrap clears at acceptance and re-sets from the new command's own steps
    drive(0, LD, 0, 0, 16'h0001);
    @(negedge clk);
    drive(0, DEC, 1, 1, 16'h0000);
    @(negedge clk);
    chk("wrapa_run_wrap", {31'b0, wrap}, 0);
    @(negedge clk);
    chk("wrapa_done", {31'b0, done}, 1);
    chk("wrapa_wrap", {31'b0, wrap}, 1);
    read_reg(0, rv); chk("wrapa_r0", rv, 16'hFFFF);
    drive(0, INC, 0, 1, 16'h0000);
    @(negedge clk);
    chk("wrapb_run_wrap", {31'b0, wrap}, 0);
    chk("wrapb_run_ready", {31'b0, cmd_ready}, 0);
    @(negedge clk);
    chk("wrapb_done", {31'b0, done}, 1);
    chk("wrapb_wrap", {31'b0, wrap}, 1);
    read_reg(0, rv); chk("wrapb_r0", rv, 16'h0000);

    // cmd_valid held through RUN: LOAD waits, then is accepted in the done cycle
    @(negedge clk);
    cmd_sel = 0; cmd_op = INC; cmd_step2 = 0; cmd_count = 3; cmd_data = '0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_sel = 1; cmd_op = LD; cmd_data = 16'h5555;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("busy_done_c%0d", c), {31'b0, done}, (c >= 4) ? 1 : 0);
      chk($sformatf("busy_ready_c%0d", c), {31'b0, cmd_ready}, (c >= 4) ? 1 : 0);
      read_reg(1, rv);
      chk($sformatf("busy_r1_c%0d", c), rv, (c == 5) ? 16'h5555 : 16'h0016);
      if (c == 4) begin
        read_reg(0, rv); chk("busy_r0_c4", rv, 16'h0003);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("busy_done_after", {31'b0, done}, 0);

    // Asynchronous reset in the middle of a long INC
    drive(1, LD, 0, 0, 16'h7777);
    @(negedge clk);
    drive(0, INC, 0, 8, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rstmid_ready_busy", {31'b0, cmd_ready}, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", {31'b0, cmd_ready}, 1);
    chk("rstmid_done", {31'b0, done}, 0);
    read_reg(0, rv); chk("rstmid_r0", rv, 0);
    read_reg(1, rv); chk("rstmid_r1", rv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("rstmid_no_done", {31'b0, saw_done}, 0);
    chk("rstmid_ready_after", {31'b0, cmd_ready}, 1);
    read_reg(0, rv); chk("rstmid_r0_after", rv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/incdec_seq.md
# incdec_seq

Sequenced pointer increment/decrement unit holding NREG address registers (PC, SP, and scratch pointers) of DATASIZE bits. It accepts one command at a time over a valid/ready handshake and applies a load, or a repeated +1/+2 or −1/−2 step, one step per clock. It reports completion and wrap-around, and sits between the control sequencer and the address bus mux.

## Interface
Parameters:
- DATASIZE, 16, register and data width in bits (≥4)
- NREG, 2, number of pointer registers (≥1)
- SELW, 1, select width; must satisfy 2^SELW ≥ NREG
- CNTW, 4, repeat-count width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit can accept a command
- cmd_sel  in  SELW  target register; values ≥ NREG are ignored (no write), but the command still completes
- cmd_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 NOP
- cmd_step2  in  1  0 = step 1, 1 = step 2
- cmd_count  in  CNTW  number of steps; 0 is treated as 1
- cmd_data  in  DATASIZE  LOAD value
- rd_sel  in  SELW  read select
- rd_data  out  DATASIZE  combinational read of register rd_sel; 0 if rd_sel ≥ NREG
- done  out  1  one-cycle pulse when a command completes
- wrap  out  1  at least one step of the last command wrapped; valid when done is high, held until the next acceptance

## Operation
- FSM states: IDLE, RUN. Reset state is IDLE.
- Reset values:
  - all registers 0
  - cmd_ready 1
  - done 0
  - wrap 0
  - internal remaining count 0
- cmd_ready = (state == IDLE).
- A command is accepted on an edge where cmd_valid && cmd_ready. At acceptance:
  - wrap clears to 0.
  - All cmd_* fields are latched; the inputs are don't-care afterwards.
- LOAD and NOP:
  - At acceptance, LOAD writes cmd_data into cmd_sel. NOP writes nothing.
  - The FSM stays in IDLE; done pulses in the next cycle.
- INC and DEC:
  - At acceptance, the FSM enters RUN with remaining = max(cmd_count, 1).
  - Each edge in RUN: reg[sel] ← reg[sel] ± step, where step is 1 or 2 zero-extended to DATASIZE, arithmetic modulo 2^DATASIZE. Remaining decrements.
  - When remaining reaches 0, the FSM returns to IDLE and done pulses.
- Wrap flag:
  - INC sets wrap when the step produces a carry out of bit DATASIZE−1, e.g. 0xFFFF+1 or 0xFFFE+2 gives 0x0000, and 0xFFFF+2 gives 0x0001.
  - DEC sets wrap on a borrow.
  - Wrap is sticky for the duration of the command.
- An out-of-range cmd_sel still runs the full step count with no register change, and wrap stays 0.
- cmd_valid while busy is ignored; no queueing.
- rd_data reflects register contents after each edge, including intermediate steps of a running command.
- An asynchronous reset mid-RUN:
  - aborts the command immediately
  - zeroes all registers and returns to IDLE
  - emits no done pulse

## Timing
- Acceptance at edge k:
  - LOAD/NOP: register updated at edge k; done high in cycle k+1; cmd_ready stays 1.
  - INC/DEC with N = max(count, 1): cmd_ready low in cycles k+1..k+N. Register updated at edges k+1..k+N. done and cmd_ready high in cycle k+N+1.
- Back-to-back commands: a new command may be accepted in the same cycle that done is high.
- done never stays high for more than one cycle for a single command.

## Test plan
- Reset, then LOAD sel0=0x1234: rd_data(0)=0x1234 one edge later, done pulses once, wrap=0, cmd_ready never drops.
- Reg1=0x0010, INC step2 count3: cmd_ready low for 3 cycles; rd_data(1) goes 0x0012, 0x0014, 0x0016; done on cycle 4; wrap=0.
- Reg0=0x0001, DEC step2 count1: result 0xFFFF, wrap=1. A following INC step1 count1 gives 0x0000 with wrap=1, and wrap is 0 between acceptance and done.
- cmd_valid held high during RUN with a different LOAD: the LOAD is ignored until cmd_ready returns, then accepted in the done cycle; both commands complete in order.
- count=0 INC step1 on 0x00FF: treated as one step, giving 0x0100. cmd_sel=3 with NREG=2: no register changes, done still pulses.
- Assert rst_n low mid-RUN (count 8 on reg0): all registers 0 immediately, no done pulse, cmd_ready=1 after release.
